// File: rtl/sprite_scheduler_pkg.sv
// Shared sprite constants and slot state encoding for the sprite scheduler.
package sprite_scheduler_pkg;

  localparam int SPRITE_HEIGHT = 8;
  localparam int SPRITE_SCALE  = 2;
  localparam int SPR_LINES_DEF = SPRITE_HEIGHT * SPRITE_SCALE;
  localparam int Y_W_DEF       = 10;
  localparam int RES_V         = 480;

  localparam logic [3:0] SPR_ID_PLAYER = 4'd0;
  localparam logic [3:0] SPR_ID_ENEMY  = 4'd1;
  localparam logic [3:0] SPR_ID_SHOT   = 4'd2;

  // DONE is the all-zero encoding so reset lands every slot there
  typedef enum logic [1:0] {
    SLOT_DONE   = 2'd0,
    SLOT_ARMED  = 2'd1,
    SLOT_ACTIVE = 2'd2
  } slot_state_t;

  function automatic int cnt_width(input int lines);
    return $clog2(lines) + 1;
  endfunction

endpackage

// File: rtl/sprite_scheduler_slot.sv
// One sprite slot: ARMED -> ACTIVE -> DONE per frame, with start pulse and line counter.
module sprite_scheduler_slot
  import sprite_scheduler_pkg::*;
#(
  parameter int SPR_LINES = SPR_LINES_DEF,
  parameter int Y_W       = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic [Y_W-1:0] line_y,
  input  logic           slot_en,
  input  logic [Y_W-1:0] slot_y,
  output logic           start,
  output logic           active
);

  localparam int CNT_W = cnt_width(SPR_LINES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPR_LINES - 1);

  slot_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_reg, start_next;
  logic             hit;

  assign hit = slot_en && (line_y == slot_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SLOT_DONE;
      cnt_reg   <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      start_reg <= start_next;
    end
  end

  // frame_start re-arms first so a same-cycle line_start can match the fresh slot
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start_next = 1'b0;
    if (frame_start) begin
      state_next = SLOT_ARMED;
      cnt_next   = '0;
    end
    case (state_next)
      SLOT_ARMED: begin
        if (line_start && hit) begin
          state_next = SLOT_ACTIVE;
          cnt_next   = '0;
          start_next = 1'b1;
        end
      end
      SLOT_ACTIVE: begin
        if (line_start) begin
          if (cnt_reg == LAST_CNT) state_next = SLOT_DONE;
          else cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign start  = start_reg;
  assign active = (state_reg == SLOT_ACTIVE);

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite scheduler top: per-slot start sequencing plus prioritized pixel merge.
// Optional sticky overlap flags are built when SPRITE_SCHED_COLLISION_EN is defined.
module sprite_scheduler
  import sprite_scheduler_pkg::*;
#(
  parameter  int NUM_SPRITES = 8,
  parameter  int SPR_LINES   = SPR_LINES_DEF,
  parameter  int Y_W         = Y_W_DEF,
  localparam int ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic [Y_W-1:0]             line_y,
  input  logic [NUM_SPRITES-1:0]     spr_en,
  input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
  input  logic [NUM_SPRITES-1:0]     spr_draw,
  output logic [NUM_SPRITES-1:0]     spr_start,
  output logic [NUM_SPRITES-1:0]     active_mask,
  output logic                       pix_valid,
  output logic [ID_W-1:0]            pix_id,
  output logic [NUM_SPRITES-1:0]     collision
);

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
      sprite_scheduler_slot #(
        .SPR_LINES(SPR_LINES),
        .Y_W      (Y_W)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .line_start (line_start),
        .line_y     (line_y),
        .slot_en    (spr_en[gi]),
        .slot_y     (spr_y[gi*Y_W +: Y_W]),
        .start      (spr_start[gi]),
        .active     (active_mask[gi])
      );
    end
  endgenerate

  logic            pix_valid_reg;
  logic [ID_W-1:0] pix_id_reg, pix_id_next;

  // scan downward so the lowest drawing slot wins
  always_comb begin
    pix_id_next = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (spr_draw[i]) pix_id_next = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid_reg <= 1'b0;
      pix_id_reg    <= '0;
    end else begin
      pix_valid_reg <= |spr_draw;
      pix_id_reg    <= pix_id_next;
    end
  end

  assign pix_valid = pix_valid_reg;
  assign pix_id    = pix_id_reg;

`ifdef SPRITE_SCHED_COLLISION_EN
  logic [NUM_SPRITES-1:0] overlap;
  logic [NUM_SPRITES-1:0] collision_reg;

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_overlap
      assign overlap[gi] = spr_draw[gi] & |(spr_draw & ~(NUM_SPRITES'(1) << gi));
    end
  endgenerate

  // a new overlap in the frame_start cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) collision_reg <= '0;
    else if (frame_start) collision_reg <= overlap;
    else collision_reg <= collision_reg | overlap;
  end

  assign collision = collision_reg;
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed plus randomized bench for sprite_scheduler against a per-slot "lines remaining" model.
module tb_sprite_scheduler;

  localparam int N   = 4;
  localparam int SPL = 16;
  localparam int YW  = 10;

  logic          clk = 1'b0;
  logic          rst, fs, ls;
  logic [YW-1:0] ly;
  logic [N-1:0]  en, draw;
  logic [N*YW-1:0] spr_y;
  logic [N-1:0]  spr_start, active_mask, collision;
  logic          pix_valid;
  logic [1:0]    pix_id;

  int total = 0;
  int bad   = 0;

  bit         started [N];
  int         left    [N];
  logic [N-1:0] exp_start, exp_act, exp_coll;
  logic       exp_valid;
  logic [1:0] exp_id;
  bit         rand_draw;

  always #5 clk = ~clk;

  sprite_scheduler #(.NUM_SPRITES(N), .SPR_LINES(SPL), .Y_W(YW)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(fs),
    .line_start (ls),
    .line_y     (ly),
    .spr_en     (en),
    .spr_y      (spr_y),
    .spr_draw   (draw),
    .spr_start  (spr_start),
    .active_mask(active_mask),
    .pix_valid  (pix_valid),
    .pix_id     (pix_id),
    .collision  (collision)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_y(input int i, input int v);
    spr_y[i*YW +: YW] = YW'(v);
  endtask

  // advance one clock: update model from current inputs, then compare registered outputs
  task automatic tick();
    logic [N-1:0] low;
    if (rand_draw) draw = N'($urandom);
    exp_start = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        started[i] = 1'b1;
        left[i]    = 0;
      end
      exp_coll  = '0;
      exp_valid = 1'b0;
      exp_id    = '0;
    end else begin
      if (fs) begin
        for (int i = 0; i < N; i++) begin
          started[i] = 1'b0;
          left[i]    = 0;
        end
        exp_coll = '0;
      end
      if (ls) begin
        for (int i = 0; i < N; i++) begin
          if (left[i] > 0) left[i]--;
          if (!started[i] && en[i] && ly == spr_y[i*YW +: YW]) begin
            started[i]   = 1'b1;
            left[i]      = SPL;
            exp_start[i] = 1'b1;
          end
        end
      end
      exp_valid = (draw != '0);
      low       = draw & (~draw + N'(1));
      exp_id    = (low == '0) ? 2'd0 : 2'($clog2(low));
`ifdef SPRITE_SCHED_COLLISION_EN
      if ($countones(draw) > 1) exp_coll |= draw;
`endif
    end
    for (int i = 0; i < N; i++) exp_act[i] = (left[i] > 0);
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b fs=%0b ls=%0b y=%0d draw=%b start=%b act=%b pv=%0b id=%0d coll=%b",
             $time, rst, fs, ls, ly, draw, spr_start, active_mask, pix_valid, pix_id, collision);
    chk("spr_start",   32'(spr_start),   32'(exp_start));
    chk("active_mask", 32'(active_mask), 32'(exp_act));
    chk("pix_valid",   32'(pix_valid),   32'(exp_valid));
    chk("pix_id",      32'(pix_id),      32'(exp_id));
    chk("collision",   32'(collision),   32'(exp_coll));
    @(negedge clk);
  endtask

  task automatic line(input int y);
    ls = 1'b1;
    ly = YW'(y);
    tick();
    ls = 1'b0;
    tick();
  endtask

  task automatic frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; ls = 1'b0; ly = '0;
    en = '0; draw = '0; spr_y = '0; rand_draw = 1'b0;
    exp_coll = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // reset in mid-frame, then no start without a new frame_start
    en = 4'b0001; set_y(0, 5);
    frame();
    for (int y = 0; y < 9; y++) line(y);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    set_y(0, 10);
    for (int y = 9; y < 13; y++) line(y);

    // single slot across its full height
    set_y(0, 40);
    frame();
    for (int y = 0; y <= 60; y++) line(y);

    // two slots on the same line, then priority merge
    en = 4'b0011; set_y(0, 100); set_y(1, 100);
    frame();
    for (int y = 98; y <= 102; y++) line(y);
    draw = 4'b0011; tick();
    draw = 4'b0010; tick();
    draw = 4'b0000; tick();

    // frame_start and line_start together, then a repeat match in the same frame
    set_y(0, 200); set_y(1, 0);
    fs = 1'b1; ls = 1'b1; ly = '0; tick();
    fs = 1'b0; ls = 1'b0; tick();
    line(0); line(1);

    // frame_start while slot 0 is mid-sprite
    en = 4'b0001; set_y(0, 40);
    frame();
    for (int y = 38; y <= 47; y++) line(y);
    frame();
    for (int y = 48; y <= 52; y++) line(y);
    for (int y = 38; y <= 42; y++) line(y);

    // overlap flags stick until frame_start
    draw = 4'b0011; tick();
    draw = 4'b0000; tick(); tick();
    frame(); tick();

    // randomized frames with random draw bits, enables and positions
    rand_draw = 1'b1;
    for (int f = 0; f < 6; f++) begin
      en = N'($urandom);
      for (int i = 0; i < N; i++) set_y(i, $urandom_range(0, 30));
      frame();
      for (int y = 0; y <= 40; y++) begin
        if ($urandom_range(0, 7) == 0) en = N'($urandom);
        if ($urandom_range(0, 15) == 0) set_y($urandom_range(0, N - 1), $urandom_range(0, 40));
        if ($urandom_range(0, 19) == 0) begin
          fs = 1'b1; ls = 1'b1; ly = YW'(y); tick();
          fs = 1'b0; ls = 1'b0; tick();
        end else begin
          line(y);
        end
      end
    end
    rand_draw = 1'b0;
    draw = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
